keypad_scanner: RTL

- Scans a 4-row x 3-column matrix keypad (phone layout) by strobing columns active-low and reading rows, mirroring how the 7-segment display is strobed one digit at a time.
- Debounces the decoded key across full scans and reports each accepted press as a 4-bit key code plus a one-cycle valid pulse.
- Sits at the board edge; its key codes feed counter/display logic.

---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/keypad_scanner_if.sv | 17 +
 rtl/keypad_debounce.sv | 84 ++++++++
 rtl/keypad_scanner.sv | 110 +++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x3 phone-layout keypad scanner.
//   Matrix geometry, special key codes, the per-scan result encoding and
//   the row/column to key-code mapping.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 3;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Outcome of one full scan: nothing, exactly one key, or several keys.
  typedef enum logic [1:0] {
    SCAN_NONE  = 2'd0,
    SCAN_ONE   = 2'd1,
    SCAN_MULTI = 2'd2
  } scan_kind_e;

  // code is only meaningful for SCAN_ONE and is kept at zero otherwise.
  typedef struct packed {
    scan_kind_e kind;
    logic [3:0] code;
  } scan_res_t;

  // Rows 0-2 carry digits 1..9; row 3 is '*', '0', '#'.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = 4'({2'b00, row} * 4'd3 + {2'b00, col} + 4'd1);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines and decoded key outputs.
//   ROW       keypad rows, active-low
//   COL       column drive, active-low one-cold
//   KEY       last accepted key code
//   KEY_VALID one-cycle pulse on a newly accepted press
//   KEY_DOWN  high while the accepted key is held
// master: the scanner; slave: keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] ROW;
  logic [2:0] COL;
  logic [3:0] KEY;
  logic       KEY_VALID;
  logic       KEY_DOWN;

  modport master (input ROW, output COL, output KEY, output KEY_VALID, output KEY_DOWN);
  modport slave  (output ROW, input COL, input KEY, input KEY_VALID, input KEY_DOWN);
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a key press or release once the same scan result
// has been seen DEBOUNCE_SCANS consecutive scans.
//   CLK, RESET_N  clock, synchronous active-low reset
//   scan_done     strobe, one cycle per completed scan
//   scan_res      result of that scan
//   KEY           last accepted key code
//   KEY_VALID     one-cycle pulse on acceptance of a new press
//   KEY_DOWN      accepted key held
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       scan_done,
  input  scan_res_t  scan_res,
  output logic [3:0] KEY,
  output logic       KEY_VALID,
  output logic       KEY_DOWN
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  scan_res_t  cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] key_q, key_d;
  logic       valid_q, valid_d;
  logic       down_q, down_d;
  logic       same;

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    valid_d = 1'b0;
    down_d  = down_q;
    same    = 1'b0;
    if (scan_done) begin
      same = (scan_res.kind == cand_q.kind) &&
             ((scan_res.kind != SCAN_ONE) || (scan_res.code == cand_q.code));
      if (same) begin
        cnt_d = (cnt_q >= DEB) ? DEB : cnt_q + 4'd1;
      end else begin
        cand_d = scan_res;
        cnt_d  = 4'd1;
      end
      // Re-evaluated every stable scan; the KEY/KEY_DOWN guard keeps a held
      // key from pulsing again while still catching a slide to a new key.
      if (cnt_d == DEB) begin
        if (cand_d.kind == SCAN_ONE) begin
          if (!down_q || (cand_d.code != key_q)) begin
            key_d   = cand_d.code;
            valid_d = 1'b1;
            down_d  = 1'b1;
          end
        end else begin
          down_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cand_q  <= '{kind: SCAN_NONE, code: 4'd0};
      cnt_q   <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      down_q  <= down_d;
    end
  end

  assign KEY       = key_q;
  assign KEY_VALID = valid_q;
  assign KEY_DOWN  = down_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes the three keypad columns active-low, reads the
// synchronized rows at the end of each column dwell, folds the hits of one
// full scan into NONE/ONE/MULTI and hands the result to keypad_debounce.
//   CLK      system clock
//   RESET_N  synchronous active-low reset
//   kp       keypad_scanner_if master: ROW in; COL, KEY, KEY_VALID, KEY_DOWN out
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned PRESCALE       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input logic                CLK,
  input logic                RESET_N,
  keypad_scanner_if.master   kp
);

  localparam int unsigned PW = (PRESCALE < 1) ? 1 : $clog2(PRESCALE + 1);

  logic [3:0]    row_s1_q, row_s1_d;
  logic [3:0]    row_s2_q, row_s2_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    col_q, col_d;
  scan_res_t     acc_q, acc_d;

  logic          tick;
  logic          scan_done;
  scan_res_t     scan_res;
  scan_res_t     merged;
  logic [2:0]    hits;
  logic [3:0]    hit_code;

  always_comb begin
    row_s1_d  = kp.ROW;
    row_s2_d  = row_s1_q;
    tick      = (presc_q == PW'(PRESCALE));
    presc_d   = tick ? '0 : presc_q + 1'b1;
    col_d     = col_q;
    acc_d     = acc_q;
    scan_done = 1'b0;
    scan_res  = acc_q;

    hits     = '0;
    hit_code = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (!row_s2_q[r]) begin
        hits     = hits + 3'd1;
        hit_code = key_code(2'(r), col_q);
      end
    end

    // Any second hit, in this column or an earlier one, is a ghosting risk.
    merged = acc_q;
    if (hits >= 3'd2) begin
      merged = '{kind: SCAN_MULTI, code: 4'd0};
    end else if (hits == 3'd1) begin
      merged = (acc_q.kind == SCAN_NONE) ? '{kind: SCAN_ONE, code: hit_code}
                                         : '{kind: SCAN_MULTI, code: 4'd0};
    end

    if (tick) begin
      if (col_q == 2'(NUM_COLS - 1)) begin
        col_d     = '0;
        scan_done = 1'b1;
        scan_res  = merged;
        acc_d     = '{kind: SCAN_NONE, code: 4'd0};
      end else begin
        col_d = col_q + 2'd1;
        acc_d = merged;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
      presc_q  <= '0;
      col_q    <= '0;
      acc_q    <= '{kind: SCAN_NONE, code: 4'd0};
    end else begin
      row_s1_q <= row_s1_d;
      row_s2_q <= row_s2_d;
      presc_q  <= presc_d;
      col_q    <= col_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    case (col_q)
      2'd0:    kp.COL = 3'b110;
      2'd1:    kp.COL = 3'b101;
      default: kp.COL = 3'b011;
    endcase
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .scan_done(scan_done),
    .scan_res (scan_res),
    .KEY      (kp.KEY),
    .KEY_VALID(kp.KEY_VALID),
    .KEY_DOWN (kp.KEY_DOWN)
  );

endmodule
